// File: rtl/blocpu_loader_pkg.sv
// blocpu_loader shared definitions: command bytes, reply bytes,
// FSM state encoding and status-byte bit positions.
package blocpu_loader_pkg;

  localparam int INSTR_W = 12;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_STAT = 8'h3F;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int ST_OVR = 4;
  localparam int ST_OK  = 3;
  localparam int ST_ERR = 2;
  localparam int ST_RST = 1;
  localparam int ST_RUN = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_INS_LO,
    S_INS_HI,
    S_WRITE,
    S_CHK,
    S_REPLY
  } state_t;

  function automatic logic [7:0] status_byte(
    input logic ovr,
    input logic ok,
    input logic err,
    input logic rst,
    input logic run
  );
    logic [7:0] b;
    b         = '0;
    b[ST_OVR] = ovr;
    b[ST_OK]  = ok;
    b[ST_ERR] = err;
    b[ST_RST] = rst;
    b[ST_RUN] = run;
    return b;
  endfunction

endpackage

// File: rtl/blocpu_loader_if.sv
// blocpu_loader bus: UART byte rx/tx handshake plus the
// core instruction-write and run-control signals.
interface blocpu_loader_if #(
  parameter int ADDR_W = 16
);
  import blocpu_loader_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic               core_reset;
  logic               core_running;
  logic [INSTR_W-1:0] core_instr;
  logic [ADDR_W-1:0]  core_addr;
  logic               core_write;
  logic               core_run_st;
  logic               core_rst_st;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    input  core_run_st, core_rst_st,
    output tx_data, tx_start,
    output core_reset, core_running,
    output core_instr, core_addr, core_write
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    output core_run_st, core_rst_st,
    input  tx_data, tx_start,
    input  core_reset, core_running,
    input  core_instr, core_addr, core_write
  );

endinterface

// File: rtl/blocpu_loader_reply.sv
// Reply holder: latches one reply byte, waits for the UART
// transmitter to go idle, then pulses tx_start for one cycle.
module blocpu_loader_reply (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] reply_byte,
  input  logic       tx_busy,
  output logic       sent,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  logic       pend_q;
  logic [7:0] byte_q;

  assign sent = pend_q & ~tx_busy;

  // hold pending byte, launch it once the transmitter is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      byte_q   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= sent;
      if (sent) tx_data <= byte_q;
      if (load) begin
        pend_q <= 1'b1;
        byte_q <= reply_byte;
      end else if (sent) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/blocpu_loader.sv
// Serial program loader / run controller for blocpu_core.
// Optional BLOCPU_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module blocpu_loader
  import blocpu_loader_pkg::*;
#(
  parameter int         ADDR_W = 16,
  parameter logic [7:0] ACK    = ACK_BYTE,
  parameter logic [7:0] NAK    = NAK_BYTE
) (
  input logic              CLK,
  input logic              RST_N,
  blocpu_loader_if.master  bus
);

  state_t             state_q, state_n;
  logic               live_q;
  logic [7:0]         cnt_lo_q, cnt_lo_n;
  logic [15:0]        rem_q, rem_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [7:0]         lo_q, lo_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic               err_q, err_n;
  logic               ok_q, ok_n;
  logic               ovr_q, ovr_n;
  logic               crst_q, crst_n;
  logic               crun_q, crun_n;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_n;
  logic               chk_bad;
`endif

  logic       rx;
  logic [15:0] cnt_full;
  logic       reply_load;
  logic [7:0] reply_byte;
  logic       reply_sent;

  // a byte arriving with the reset release edge is never taken
  assign rx       = bus.rx_valid & live_q;
  assign cnt_full = {bus.rx_data, cnt_lo_q};

  // next-state and datapath decisions
  always_comb begin
    state_n    = state_q;
    cnt_lo_n   = cnt_lo_q;
    rem_n      = rem_q;
    addr_n     = addr_q;
    lo_n       = lo_q;
    instr_n    = instr_q;
    err_n      = err_q;
    ok_n       = ok_q;
    ovr_n      = ovr_q;
    crst_n     = crst_q;
    crun_n     = crun_q;
    reply_load = 1'b0;
    reply_byte = ACK;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    csum_n     = csum_q;
    chk_bad    = err_q | (bus.rx_data != csum_q);
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx) begin
          unique case (1'b1)
            (bus.rx_data == CMD_LOAD): begin
              state_n = S_CNT_LO;
              crst_n  = 1'b1;
              crun_n  = 1'b0;
              ok_n    = 1'b0;
              err_n   = 1'b0;
              ovr_n   = 1'b0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
              csum_n  = '0;
`endif
            end
            (bus.rx_data == CMD_RUN): begin
              state_n    = S_REPLY;
              reply_load = 1'b1;
              if (ok_q) begin
                crst_n     = 1'b0;
                crun_n     = 1'b1;
                reply_byte = ACK;
              end else begin
                reply_byte = NAK;
              end
            end
            (bus.rx_data == CMD_HALT): begin
              state_n    = S_REPLY;
              reply_load = 1'b1;
              crun_n     = 1'b0;
              reply_byte = ACK;
            end
            (bus.rx_data == CMD_STAT): begin
              state_n    = S_REPLY;
              reply_load = 1'b1;
              reply_byte = status_byte(ovr_q, ok_q, err_q,
                                       bus.core_rst_st,
                                       bus.core_run_st);
            end
            default: begin
              state_n    = S_REPLY;
              reply_load = 1'b1;
              reply_byte = NAK;
            end
          endcase
        end
      end
      S_CNT_LO: begin
        if (rx) begin
          cnt_lo_n = bus.rx_data;
          state_n  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (rx) begin
          if (cnt_full == 16'd0) begin
            ok_n       = 1'b1;
            reply_load = 1'b1;
            reply_byte = ACK;
            state_n    = S_REPLY;
          end else begin
            rem_n   = cnt_full;
            addr_n  = '0;
            state_n = S_INS_LO;
          end
        end
      end
      S_INS_LO: begin
        if (rx) begin
          lo_n    = bus.rx_data;
          state_n = S_INS_HI;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          csum_n  = csum_q ^ bus.rx_data;
`endif
        end
      end
      S_INS_HI: begin
        if (rx) begin
          instr_n = {bus.rx_data[3:0], lo_q};
          if (bus.rx_data[7:4] != 4'h0) err_n = 1'b1;
          state_n = S_WRITE;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          csum_n  = csum_q ^ bus.rx_data;
`endif
        end
      end
      S_WRITE: begin
        addr_n = addr_q + 1'b1;
        rem_n  = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          state_n = S_CHK;
`else
          ok_n       = ~err_q;
          reply_load = 1'b1;
          reply_byte = err_q ? NAK : ACK;
          state_n    = S_REPLY;
`endif
        end else begin
          state_n = S_INS_LO;
        end
      end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx) begin
          err_n      = chk_bad;
          ok_n       = ~chk_bad;
          reply_load = 1'b1;
          reply_byte = chk_bad ? NAK : ACK;
          state_n    = S_REPLY;
        end
      end
`endif
      S_REPLY: begin
        if (rx) ovr_n = 1'b1;
        if (reply_sent) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      live_q   <= 1'b0;
      cnt_lo_q <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      lo_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      ok_q     <= 1'b0;
      ovr_q    <= 1'b0;
      crst_q   <= 1'b1;
      crun_q   <= 1'b0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      live_q   <= 1'b1;
      cnt_lo_q <= cnt_lo_n;
      rem_q    <= rem_n;
      addr_q   <= addr_n;
      lo_q     <= lo_n;
      instr_q  <= instr_n;
      err_q    <= err_n;
      ok_q     <= ok_n;
      ovr_q    <= ovr_n;
      crst_q   <= crst_n;
      crun_q   <= crun_n;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      csum_q   <= csum_n;
`endif
    end
  end

  assign bus.core_reset   = crst_q;
  assign bus.core_running = crun_q;
  assign bus.core_instr   = instr_q;
  assign bus.core_addr    = addr_q;
  assign bus.core_write   = (state_q == S_WRITE);

  blocpu_loader_reply u_reply (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (reply_load),
    .reply_byte (reply_byte),
    .tx_busy    (bus.tx_busy),
    .sent       (reply_sent),
    .tx_data    (bus.tx_data),
    .tx_start   (bus.tx_start)
  );

endmodule

// File: tb/tb_blocpu_loader.sv
// Scoreboard bench for blocpu_loader: directed scenarios plus
// random command/load traffic against a behavioural model.
module tb_blocpu_loader;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blocpu_loader_if #(.ADDR_W(16)) bus ();

  blocpu_loader dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_tx = 0;
  int busy_cnt = 0;
  logic force_busy = 1'b0;

  logic [7:0]  exp_tx[$];
  logic [27:0] exp_wr[$];

  bit m_loaded, m_err, m_ovr, m_rst, m_run;

  assign bus.tx_busy     = force_busy | (busy_cnt != 0);
  assign bus.core_rst_st = bus.core_reset;
  assign bus.core_run_st = bus.core_running;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transmitter model: busy for a random few cycles after each start
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= $urandom_range(0, 4);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // monitor: pop and compare every reply byte and instruction write
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        n_tx++;
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got %h expected none", bus.tx_data);
        end else begin
          check("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
        end
      end
      if (bus.core_write) begin
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got %h/%h expected none",
                   bus.core_addr, bus.core_instr);
        end else begin
          check("core_write", {4'h0, bus.core_addr, bus.core_instr},
                {4'h0, exp_wr.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_reply(input int t0, input string name);
    for (int i = 0; i < 300 && n_tx == t0; i++) @(negedge clk);
    if (n_tx == t0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no reply expected one within 300 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic check_core(input string name);
    check({name, "_core_reset"}, {31'h0, bus.core_reset}, {31'h0, m_rst});
    check({name, "_core_running"}, {31'h0, bus.core_running}, {31'h0, m_run});
  endtask

  task automatic do_load(input logic [7:0] ins[$], input logic [7:0] chk_xor);
    logic [7:0] seq[$];
    logic [7:0] lo, hi, cs;
    bit e;
    int n, t0;
    n  = ins.size() / 2;
    cs = 8'h00;
    e  = 1'b0;
    seq.push_back(8'h4C);
    seq.push_back(n[7:0]);
    seq.push_back(n[15:8]);
    for (int k = 0; k < n; k++) begin
      lo = ins[2*k];
      hi = ins[2*k+1];
      exp_wr.push_back({k[15:0], hi[3:0], lo});
      if (hi[7:4] != 4'h0) e = 1'b1;
      cs = cs ^ lo ^ hi;
      seq.push_back(lo);
      seq.push_back(hi);
    end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    if (n > 0) begin
      seq.push_back(cs ^ chk_xor);
      if (chk_xor != 8'h00) e = 1'b1;
    end
`else
    if (chk_xor != 8'h00) cs = 8'h00;
`endif
    m_rst = 1'b1;
    m_run = 1'b0;
    m_ovr = 1'b0;
    m_err = e;
    m_loaded = !e;
    exp_tx.push_back(e ? NAK : ACK);
    t0 = n_tx;
    foreach (seq[i]) begin
      send_byte(seq[i]);
      gap();
    end
    wait_reply(t0, "load_reply");
    check_core("load");
  endtask

  task automatic cmd(input logic [7:0] b);
    logic [7:0] exp;
    int t0;
    if (b == 8'h52) begin
      exp = m_loaded ? ACK : NAK;
      if (m_loaded) begin
        m_rst = 1'b0;
        m_run = 1'b1;
      end
    end else if (b == 8'h48) begin
      exp = ACK;
      m_run = 1'b0;
    end else if (b == 8'h3F) begin
      exp = {3'b000, m_ovr, m_loaded, m_err, m_rst, m_run};
    end else begin
      exp = NAK;
    end
    exp_tx.push_back(exp);
    t0 = n_tx;
    send_byte(b);
    check_core("cmd_next_cycle");
    wait_reply(t0, "cmd_reply");
  endtask

  task automatic model_reset();
    m_loaded = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    m_rst = 1'b1;
    m_run = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rst"},   {31'h0, bus.core_reset},   32'h1);
    check({name, "_run"},   {31'h0, bus.core_running}, 32'h0);
    check({name, "_wr"},    {31'h0, bus.core_write},   32'h0);
    check({name, "_instr"}, {20'h0, bus.core_instr},   32'h0);
    check({name, "_addr"},  {16'h0, bus.core_addr},    32'h0);
    check({name, "_txs"},   {31'h0, bus.tx_start},     32'h0);
    check({name, "_txd"},   {24'h0, bus.tx_data},      32'h0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int t0, n, op;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cmd(8'h52);

    q = '{8'h34, 8'h01, 8'hFF, 8'h0A};
    do_load(q, 8'h00);
    cmd(8'h52);
    cmd(8'h48);

    q = '{8'h00, 8'hF3};
    do_load(q, 8'h00);
    cmd(8'h3F);

    q.delete();
    do_load(q, 8'h00);
    cmd(8'h5A);

`ifdef BLOCPU_LOADER_CHECKSUM_EN
    q = '{8'h34, 8'h01};
    do_load(q, 8'h00);
    do_load(q, 8'h35);
`endif

    force_busy = 1'b1;
    exp_tx.push_back(ACK);
    m_run = 1'b0;
    t0 = n_tx;
    send_byte(8'h48);
    gap();
    send_byte(8'h3F);
    m_ovr = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_holds_tx", n_tx, t0);
    force_busy = 1'b0;
    wait_reply(t0, "busy_release");
    cmd(8'h3F);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0) begin
        n = $urandom_range(0, 5);
        q.delete();
        for (int k = 0; k < n; k++) begin
          q.push_back(8'($urandom));
          if ($urandom_range(0, 4) == 0) q.push_back(8'($urandom));
          else q.push_back({4'h0, 4'($urandom)});
        end
        do_load(q, ($urandom_range(0, 3) == 0) ? 8'h5C : 8'h00);
      end else if (op == 1) begin
        cmd(8'h52);
      end else if (op == 2) begin
        cmd(8'h48);
      end else if (op == 3) begin
        cmd(8'h3F);
      end else begin
        do b = 8'($urandom);
        while (b == 8'h4C || b == 8'h52 || b == 8'h48 || b == 8'h3F);
        cmd(b);
      end
    end

    send_byte(8'h4C);
    gap();
    send_byte(8'h02);
    gap();
    send_byte(8'h00);
    gap();
    send_byte(8'h34);
    gap();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    t0 = n_tx;
    rst_n = 1'b1;
    bus.rx_data  = 8'h3F;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("release_byte_ignored", n_tx, t0);
    check_core("after_abort");
    cmd(8'h3F);

    repeat (10) @(negedge clk);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
